pwm_out_stage: RTL and testbench

- Downstream stage of the I-PD controller. Converts the signed controller output pidk into an edge-aligned PWM drive signal.
- Applies arithmetic scaling and saturation to pidk.
- Generates the sample-enable strobe EN that paces the controller, so controller and actuator stay phase-locked to PWM period boundaries.

---
 rtl/pid_pkg.sv | 27 ++
 rtl/pwm_saturator.sv | 41 ++++
 rtl/pwm_out_stage.sv | 177 +++++++++++++++++
 tb/tb_pwm_out_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared types and defaults for the I-PD controller output path.
// Holds the PWM stage FSM encoding and the duty saturation bounds.
package pid_pkg;

    localparam int SIZE_DEF     = 19;
    localparam int PWM_BITS_DEF = 10;
    localparam int SHIFT_DEF    = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STOP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        RUN  = S_RUN,
        STOP = S_STOP
    } pwm_state_e;

    // Largest duty a PWM_BITS-wide counter can express.
    function automatic int sat_max(input int bits);
        return (1 << bits) - 1;
    endfunction

    localparam int SAT_MIN     = 0;
    localparam int SAT_MAX_DEF = sat_max(PWM_BITS_DEF);

endpackage

// File: rtl/pwm_saturator.sv
// Scales the signed controller output by an arithmetic shift and clips it to the duty range.
// Purely combinational, zero latency; no flow control.
// Negative values clip to 0 (o_lo), values above the counter range clip to all-ones (o_hi).
module pwm_saturator
    import pid_pkg::*;
#(
    parameter int SIZE     = SIZE_DEF,
    parameter int SHIFT    = SHIFT_DEF,
    parameter int PWM_BITS = PWM_BITS_DEF
) (
    input  logic signed [SIZE-1:0]     i_pidk,
    output logic        [PWM_BITS-1:0] o_value,
    output logic                       o_hi,
    output logic                       o_lo
);

    localparam int LIM_I = sat_max(PWM_BITS);

    logic signed [SIZE-1:0] w_v;
    logic signed [SIZE-1:0] w_lim;
    logic                   w_lo;
    logic                   w_hi;

    assign w_v   = i_pidk >>> SHIFT;
    assign w_lim = SIZE'(LIM_I);
    assign w_lo  = w_v[SIZE-1];
    assign w_hi  = !w_lo && (w_v > w_lim);

    always_comb begin
        o_value = w_v[PWM_BITS-1:0];
        if (w_lo) begin
            o_value = '0;
        end else if (w_hi) begin
            o_value = '1;
        end
    end

    assign o_hi = w_hi;
    assign o_lo = w_lo;

endmodule

// File: rtl/pwm_out_stage.sv
// Edge-aligned PWM output stage with boundary-shadowed duty and controller sample strobe EN.
// Latency: pwm lags the counter by one clk; a new pidk reaches pwm at the next period boundary.
// No backpressure: free-running while busy; optional complementary output under PWM_DEADTIME_EN.
module pwm_out_stage
    import pid_pkg::*;
#(
    parameter int SIZE           = SIZE_DEF,
    parameter int PWM_BITS       = PWM_BITS_DEF,
    parameter int SHIFT          = SHIFT_DEF,
    parameter int DIV            = 4,
    parameter int SAMPLE_PERIODS = 2
`ifdef PWM_DEADTIME_EN
    ,
    parameter int DEAD           = 2
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       run,
    input  logic signed [SIZE-1:0]     pidk,
    output logic                       EN,
    output logic                       pwm,
    output logic        [PWM_BITS-1:0] duty,
    output logic                       sat_hi,
    output logic                       sat_lo,
    output logic                       busy
`ifdef PWM_DEADTIME_EN
    ,
    output logic                       pwm_n
`endif
);

    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PER_W = (SAMPLE_PERIODS > 1) ? $clog2(SAMPLE_PERIODS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIODS - 1);

    pwm_state_e          r_state;
    logic [PRE_W-1:0]    r_pre;
    logic [PWM_BITS-1:0] r_cnt;
    logic [PER_W-1:0]    r_per;
    logic [PWM_BITS-1:0] r_duty;
    logic                r_sat_hi;
    logic                r_sat_lo;
    logic                r_pwm;
    logic                r_en;

    logic [PWM_BITS-1:0] w_sat_value;
    logic                w_sat_hi;
    logic                w_sat_lo;
    logic                w_tick;
    logic                w_period_end;
    logic                w_to_idle;
    logic                w_drive;
    logic                w_pwm_on;

    pwm_saturator #(
        .SIZE     (SIZE),
        .SHIFT    (SHIFT),
        .PWM_BITS (PWM_BITS)
    ) u_sat (
        .i_pidk  (pidk),
        .o_value (w_sat_value),
        .o_hi    (w_sat_hi),
        .o_lo    (w_sat_lo)
    );

    assign w_tick       = (r_state != IDLE) && (r_pre == PRE_LAST);
    assign w_period_end = w_tick && (r_cnt == '1);
    assign w_to_idle    = (r_state == STOP) && w_period_end && !run;
    // Leaving STOP forces the outputs low on the same edge the counters clear.
    assign w_drive      = (r_state != IDLE) && !w_to_idle;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else if ((r_state == IDLE) || w_to_idle) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_per    <= '0;
            r_duty   <= '0;
            r_sat_hi <= 1'b0;
            r_sat_lo <= 1'b0;
            r_en     <= 1'b0;
        end else begin
            r_en <= (r_state == RUN) && w_period_end && (r_per == PER_LAST);
            case (r_state)
                IDLE: begin
                    if (run) begin
                        r_state  <= RUN;
                        r_duty   <= w_sat_value;
                        r_sat_hi <= w_sat_hi;
                        r_sat_lo <= w_sat_lo;
                    end
                end
                RUN: begin
                    if (w_period_end) begin
                        r_duty   <= w_sat_value;
                        r_sat_hi <= w_sat_hi;
                        r_sat_lo <= w_sat_lo;
                        r_per    <= (r_per == PER_LAST) ? '0 : r_per + 1'b1;
                    end
                    if (!run) begin
                        r_state <= STOP;
                    end
                end
                STOP: begin
                    // The sample phase is frozen while draining so EN stays quiet.
                    if (w_period_end) begin
                        if (run) begin
                            r_state  <= RUN;
                            r_duty   <= w_sat_value;
                            r_sat_hi <= w_sat_hi;
                            r_sat_lo <= w_sat_lo;
                        end else begin
                            r_state  <= IDLE;
                            r_per    <= '0;
                            r_sat_hi <= 1'b0;
                            r_sat_lo <= 1'b0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef PWM_DEADTIME_EN
    localparam logic [PWM_BITS:0] DEAD_C = (PWM_BITS + 1)'(DEAD);

    logic w_pwm_n_on;
    logic r_pwm_n;

    assign w_pwm_on   = ({1'b0, r_cnt} >= DEAD_C) && (r_cnt < r_duty);
    assign w_pwm_n_on = {1'b0, r_cnt} >= ({1'b0, r_duty} + DEAD_C);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pwm_n <= 1'b0;
        end else begin
            r_pwm_n <= w_drive && w_pwm_n_on;
        end
    end

    assign pwm_n = r_pwm_n;
`else
    assign w_pwm_on = r_cnt < r_duty;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= w_drive && w_pwm_on;
        end
    end

    assign EN     = r_en;
    assign pwm    = r_pwm;
    assign duty   = r_duty;
    assign sat_hi = r_sat_hi;
    assign sat_lo = r_sat_lo;
    assign busy   = (r_state != IDLE);

endmodule

// File: tb/tb_pwm_out_stage.sv
// Directed bench for pwm_out_stage (PWM_BITS=4, DIV=1, SHIFT=0, SAMPLE_PERIODS=2).
// Expected per-cycle outputs are queued as stimulus is applied and checked on the falling edge.
module tb_pwm_out_stage;

    localparam int SIZE = 19;
    localparam int PB   = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   run;
    logic signed [SIZE-1:0] pidk;
    logic                   EN;
    logic                   pwm;
    logic [PB-1:0]          duty;
    logic                   sat_hi;
    logic                   sat_lo;
    logic                   busy;
`ifdef PWM_DEADTIME_EN
    logic                   pwm_n;
`endif

    pwm_out_stage #(
        .SIZE           (SIZE),
        .PWM_BITS       (PB),
        .SHIFT          (0),
        .DIV            (1),
        .SAMPLE_PERIODS (2)
`ifdef PWM_DEADTIME_EN
        ,
        .DEAD           (2)
`endif
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .pidk   (pidk),
        .EN     (EN),
        .pwm    (pwm),
        .duty   (duty),
        .sat_hi (sat_hi),
        .sat_lo (sat_lo),
        .busy   (busy)
`ifdef PWM_DEADTIME_EN
        ,
        .pwm_n  (pwm_n)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [9:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_assert  = 0;
    int   n_fail    = 0;
    int   prev_d    = 0;
    bit   from_idle = 1'b1;

    // {pwm, pwm_n, EN, busy, sat_hi, sat_lo, duty}
    function automatic logic [9:0] obs_vec();
        logic pn;
`ifdef PWM_DEADTIME_EN
        pn = pwm_n;
`else
        pn = 1'b0;
`endif
        return {pwm, pn, EN, busy, sat_hi, sat_lo, duty};
    endfunction

    function automatic logic exp_pwm(int c, int d);
`ifdef PWM_DEADTIME_EN
        return (c >= 2) && (c < d);
`else
        return c < d;
`endif
    endfunction

    function automatic logic exp_pwmn(int c, int d);
`ifdef PWM_DEADTIME_EN
        return c >= d + 2;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int exp_high(int d);
`ifdef PWM_DEADTIME_EN
        return (d > 2) ? d - 2 : 0;
`else
        return d;
`endif
    endfunction

    task automatic push(string tag, logic p, logic pn, logic en, logic b, logic hi, logic lo, int d);
        exp_t e;
        logic [PB-1:0] dv;
        dv    = PB'(d);
        e.tag = tag;
        e.v   = {p, pn, en, b, hi, lo, dv};
        sb.push_back(e);
    endtask

    task automatic check_now();
        exp_t e;
        logic [9:0] o;
        e = sb.pop_front();
        o = obs_vec();
        n_assert++;
        assert (o === e.v)
        else begin
            n_fail++;
            $error("FAIL %s observed=%b required=%b", e.tag, o, e.v);
        end
    endtask

    task automatic idle_cycles(string tag, int n, int d);
        for (int i = 0; i < n; i++) begin
            push($sformatf("%s c%0d", tag, i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, d);
            @(negedge clk);
            check_now();
        end
    endtask

    // Checks one PWM period (len cycles from cnt=0); inputs may change after the check at cnt=k.
    task automatic run_period(string tag, int d, logic hi, logic lo, logic en0, int len,
                              int chg_k, logic signed [SIZE-1:0] chg_pidk, int stop_k, int resume_k);
        int highs;
        logic ep;
        logic epn;
        highs = 0;
        for (int k = 0; k < len; k++) begin
            if (k == 0) begin
                ep  = 1'b0;
                epn = from_idle ? 1'b0 : exp_pwmn(15, prev_d);
            end else begin
                ep  = exp_pwm(k - 1, d);
                epn = exp_pwmn(k - 1, d);
            end
            push($sformatf("%s k%0d", tag, k), ep, epn, (k == 0) && en0, 1'b1, hi, lo, d);
            @(negedge clk);
            check_now();
            if (pwm === 1'b1) highs++;
            if (k == chg_k) pidk = chg_pidk;
            if (k == stop_k) run = 1'b0;
            if (k == resume_k) run = 1'b1;
        end
        if (len == 16) begin
            n_assert++;
            assert (highs === exp_high(d))
            else begin
                n_fail++;
                $error("FAIL %s high_count observed=%0d required=%0d", tag, highs, exp_high(d));
            end
        end
        prev_d    = d;
        from_idle = 1'b0;
    endtask

    initial begin
        rst  = 1'b0;
        run  = 1'b0;
        pidk = '0;
        repeat (2) @(negedge clk);
        push("reset_state", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check_now();
        rst = 1'b1;
        idle_cycles("idle_after_reset", 3, 0);

        // Steady duty 5, EN every second period, then mid-period updates and saturation.
        pidk = 19'sd5;
        run  = 1'b1;
        run_period("steady p0", 5, 1'b0, 1'b0, 1'b0, 16, -1, 19'sd0, -1, -1);
        run_period("steady p1", 5, 1'b0, 1'b0, 1'b0, 16, -1, 19'sd0, -1, -1);
        run_period("steady p2", 5, 1'b0, 1'b0, 1'b1, 16, -1, 19'sd0, -1, -1);
        run_period("midupd p3", 5, 1'b0, 1'b0, 1'b0, 16, 3, 19'sd10, -1, -1);
        run_period("midupd p4", 10, 1'b0, 1'b0, 1'b1, 16, 5, -19'sd3, -1, -1);
        run_period("satlo p5", 0, 1'b0, 1'b1, 1'b0, 16, 8, 19'sd40, -1, -1);
        run_period("sathi p6", 15, 1'b1, 1'b0, 1'b1, 16, -1, 19'sd0, -1, -1);
        run_period("stop p7", 15, 1'b1, 1'b0, 1'b0, 16, -1, 19'sd0, 7, -1);
        idle_cycles("stop_idle", 3, 15);
        from_idle = 1'b1;

        // Stop requested then withdrawn before the boundary: no gap back into RUN.
        pidk = 19'sd7;
        run  = 1'b1;
        run_period("resume q0", 7, 1'b0, 1'b0, 1'b0, 16, -1, 19'sd0, 7, 12);
        run_period("resume q1", 7, 1'b0, 1'b0, 1'b0, 8, -1, 19'sd0, -1, -1);

        // Asynchronous reset in the middle of a period (cnt=7).
        rst = 1'b0;
        run = 1'b0;
        #1;
        push("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check_now();
        @(negedge clk);
        push("reset_held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check_now();
        rst = 1'b1;
        idle_cycles("idle_after_async", 3, 0);
        from_idle = 1'b1;

        pidk = 19'sd5;
        run  = 1'b1;
        run_period("post_reset", 5, 1'b0, 1'b0, 1'b0, 16, -1, 19'sd0, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
